// File: rtl/dma_writer_2d_if.sv
// Bus bundle for dma_writer_2d: the producer stream side and the memory write port.
// Both sides use valid/ready: a word moves only in a cycle where the valid (src_strobe / mem_wr) and the ready (src_ready / mem_rdy) are both high.
interface dma_writer_2d_if;
    logic [31:0] src_data;
    logic        src_strobe;
    logic        src_ready;
    logic        src_done;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wr;
    logic        mem_rdy;

    modport master (
        input  src_data, src_strobe, mem_rdy,
        output src_ready, src_done, mem_addr, mem_data, mem_wr
    );

    modport slave (
        output src_data, src_strobe, mem_rdy,
        input  src_ready, src_done, mem_addr, mem_data, mem_wr
    );
endinterface

// File: rtl/dma_writer_2d.sv
// Buffered 2D DMA writer: a FIFO absorbs producer words, and the writer drains them
// to memory in rows of row_len words, with each row base advanced by stride bytes.
module dma_writer_2d #(
    parameter int FIFO_DEPTH = 512,
    parameter int LEN_W      = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 dst_addr,
    input  logic [LEN_W-1:0]            row_len,
    input  logic [LEN_W-1:0]            rows,
    input  logic [31:0]                 stride,
    input  logic                        run,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [1:0]                  dbg_state,
    dma_writer_2d_if.master             bus
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int CW = 2 * LEN_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ABORT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   src_left_q, src_left_d;
    logic [CW-1:0]   mem_left_q, mem_left_d;
    logic [31:0]     row_base_q, row_base_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     stride_q, stride_d;
    logic [LEN_W-1:0] col_q, col_d;
    logic [LEN_W-1:0] row_len_q, row_len_d;
    logic [PW-1:0]   wrptr_q, wrptr_d;
    logic [PW-1:0]   rdptr_q, rdptr_d;
    logic            mem_wr_q, mem_wr_d;
    logic [PW-1:0]   level;
    logic            src_ready;
    logic            push;
    logic            pop;
    logic [31:0]     fifo_mem [FIFO_DEPTH];

    assign level     = wrptr_q - rdptr_q;
    assign src_ready = (state_q == S_ACTIVE) && (src_left_q != '0) && (level < PW'(FIFO_DEPTH));
    assign push      = bus.src_strobe && src_ready;
    assign pop       = mem_wr_q && bus.mem_rdy;

    always_comb begin
        state_d    = state_q;
        src_left_d = src_left_q;
        mem_left_d = mem_left_q;
        row_base_d = row_base_q;
        mem_addr_d = mem_addr_q;
        stride_d   = stride_q;
        col_d      = col_q;
        row_len_d  = row_len_q;
        wrptr_d    = wrptr_q;
        rdptr_d    = rdptr_q;
        mem_wr_d   = mem_wr_q;

        if (push) begin
            wrptr_d    = wrptr_q + 1'b1;
            src_left_d = src_left_q - 1'b1;
        end
        if (pop) begin
            rdptr_d    = rdptr_q + 1'b1;
            mem_left_d = mem_left_q - 1'b1;
            // The last column jumps to the next row base; all other columns step one word.
            if (col_q == row_len_q - 1'b1) begin
                col_d      = '0;
                row_base_d = row_base_q + stride_q;
                mem_addr_d = row_base_q + stride_q;
            end else begin
                col_d      = col_q + 1'b1;
                mem_addr_d = mem_addr_q + 32'd4;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                mem_wr_d = 1'b0;
                if (run && (row_len != '0) && (rows != '0)) begin
                    state_d    = S_ACTIVE;
                    row_len_d  = row_len;
                    stride_d   = {stride[31:2], 2'b00};
                    src_left_d = CW'(row_len) * CW'(rows);
                    mem_left_d = CW'(row_len) * CW'(rows);
                    row_base_d = {dst_addr[31:2], 2'b00};
                    mem_addr_d = {dst_addr[31:2], 2'b00};
                    col_d      = '0;
                end
            end
            S_ACTIVE: begin
                if (abort && mem_wr_q && !bus.mem_rdy) begin
                    state_d = S_ABORT;
                end else if (abort) begin
                    state_d  = S_IDLE;
                    mem_wr_d = 1'b0;
                end else if (pop && (mem_left_q == CW'(1))) begin
                    state_d  = S_IDLE;
                    mem_wr_d = 1'b0;
                end else if (pop) begin
                    // Stay back-to-back only if a word is left after this pop.
                    mem_wr_d = (level != PW'(1)) || push;
                end else if (!mem_wr_q) begin
                    mem_wr_d = (level != '0) || push;
                end
            end
            S_ABORT: begin
                if (bus.mem_rdy) begin
                    state_d  = S_IDLE;
                    mem_wr_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                mem_wr_d = 1'b0;
            end
        endcase

        // Leaving a transfer discards the buffered words and any uncounted remainder.
        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            wrptr_d    = '0;
            rdptr_d    = '0;
            src_left_d = '0;
            mem_left_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_left_q <= '0;
            mem_left_q <= '0;
            row_base_q <= '0;
            mem_addr_q <= '0;
            stride_q   <= '0;
            col_q      <= '0;
            row_len_q  <= '0;
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_left_q <= src_left_d;
            mem_left_q <= mem_left_d;
            row_base_q <= row_base_d;
            mem_addr_q <= mem_addr_d;
            stride_q   <= stride_d;
            col_q      <= col_d;
            row_len_q  <= row_len_d;
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wrptr_q[AW-1:0]] <= bus.src_data;
        end
    end

    assign bus.src_ready = src_ready;
    assign bus.src_done  = (src_left_q == '0);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = fifo_mem[rdptr_q[AW-1:0]];
    assign bus.mem_wr    = mem_wr_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_IDLE);
    assign fifo_level    = level;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_dma_writer_2d.sv
// Bench for dma_writer_2d: a transfer-level model (word counts, address formula, data queue)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_dma_writer_2d;
    localparam int DEPTH = 4;
    localparam int LW    = 16;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic [31:0]   dst_addr;
    logic [LW-1:0] row_len;
    logic [LW-1:0] rows;
    logic [31:0]   stride;
    logic          run;
    logic          abort;
    logic          busy;
    logic          done;
    logic [PW-1:0] fifo_level;
    logic [1:0]    dbg_state;

    dma_writer_2d_if bus ();

    dma_writer_2d #(.FIFO_DEPTH(DEPTH), .LEN_W(LW)) dut (
        .clk        (clk),
        .reset      (reset),
        .dst_addr   (dst_addr),
        .row_len    (row_len),
        .rows       (rows),
        .stride     (stride),
        .run        (run),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level),
        .dbg_state  (dbg_state),
        .bus        (bus.master)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // transfer-level model: 0 idle, 1 running, 2 finishing the in-flight write after abort
    int          m_st = 0;
    longint      n_total = 0;
    longint      pushed = 0;
    longint      written = 0;
    longint      lvl;
    longint      m_rowlen = 1;
    logic [31:0] m_base = '0;
    logic [31:0] m_stride4 = '0;
    logic [31:0] exp_q[$];
    logic        e_rdy, e_wr, accept, do_push;
    logic        hold_v = 1'b0;
    logic [31:0] prev_addr, prev_data;
    int          cyc_n = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];

    function automatic logic [31:0] exp_addr(input longint idx);
        logic [31:0] r;
        logic [31:0] c;
        r = 32'(idx / m_rowlen);
        c = 32'(idx % m_rowlen);
        return m_base + r * m_stride4 + (c << 2);
    endfunction

    task automatic model_idle();
        m_st = 0;
        exp_q.delete();
        n_total = 0;
        pushed  = 0;
        written = 0;
    endtask

    // scoreboard / compare process: checks the cycle, then commits it to the model
    always @(negedge clk) begin
        cyc_n++;
        if (reset) begin
            model_idle();
            hold_v = 1'b0;
        end else begin
            lvl   = pushed - written;
            e_rdy = (m_st == 1) && (pushed < n_total) && (lvl < DEPTH);
            e_wr  = (m_st == 2) || ((m_st == 1) && (lvl > 0));
            check("busy", busy, m_st != 0);
            check("done", done, m_st == 0);
            check("src_ready", bus.src_ready, e_rdy);
            check("src_done", bus.src_done, pushed == n_total);
            check("fifo_level", fifo_level, lvl);
            check("mem_wr", bus.mem_wr, e_wr);
            if (hold_v) begin
                check("hold_addr", bus.mem_addr, prev_addr);
                check("hold_data", bus.mem_data, prev_data);
            end
            accept = e_wr && bus.mem_rdy;
            if (accept) begin
                check("wr_addr", bus.mem_addr, exp_addr(written));
                check("wr_data", bus.mem_data, (exp_q.size() > 0) ? exp_q[0] : 32'hDEAD_BEEF);
                log_addr.push_back(bus.mem_addr);
                log_data.push_back(bus.mem_data);
                log_cyc.push_back(cyc_n);
            end
            hold_v    = bus.mem_wr && !bus.mem_rdy;
            prev_addr = bus.mem_addr;
            prev_data = bus.mem_data;
            do_push   = bus.src_strobe && e_rdy;
            case (m_st)
                0: begin
                    if (run && (row_len != 0) && (rows != 0)) begin
                        m_st      = 1;
                        n_total   = longint'(row_len) * longint'(rows);
                        m_rowlen  = longint'(row_len);
                        m_base    = {dst_addr[31:2], 2'b00};
                        m_stride4 = {stride[31:2], 2'b00};
                        pushed    = 0;
                        written   = 0;
                        exp_q.delete();
                    end
                end
                1: begin
                    if (do_push) begin
                        exp_q.push_back(bus.src_data);
                        pushed++;
                    end
                    if (accept) begin
                        void'(exp_q.pop_front());
                        written++;
                    end
                    if (abort) begin
                        if ((lvl > 0) && !bus.mem_rdy) m_st = 2;
                        else model_idle();
                    end else if (written == n_total) begin
                        model_idle();
                    end
                end
                default: begin
                    if (bus.mem_rdy) model_idle();
                end
            endcase
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input int rl, input int rw, input logic [31:0] st);
        dst_addr = a;
        row_len  = LW'(rl);
        rows     = LW'(rw);
        stride   = st;
        run      = 1'b1;
        tick();
        run      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    function automatic logic [31:0] log_a(input int i);
        return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic rand_xfer(input bit do_abort);
        int n;
        int ab_at;
        logic [31:0] st;
        int sel;
        n     = 0;
        ab_at = $urandom_range(1, 12);
        sel   = $urandom_range(0, 2);
        st    = (sel == 0) ? 32'h0 : (sel == 1) ? 32'h40 : $urandom;
        start($urandom, $urandom_range(1, 5), $urandom_range(1, 4), st);
        while (busy && n < 2000) begin
            bus.src_strobe = ($urandom_range(0, 99) < 70);
            bus.src_data   = $urandom;
            bus.mem_rdy    = ($urandom_range(0, 99) < 60);
            abort          = do_abort && (n == ab_at);
            if (abort) bus.mem_rdy = 1'b0;
            tick();
            n++;
        end
        abort          = 1'b0;
        bus.src_strobe = 1'b0;
        bus.mem_rdy    = 1'b0;
        check("rand_timeout", busy, 1'b0);
    endtask

    logic [31:0] t1_addr[4];
    logic [31:0] t2_addr[6];

    initial begin
        reset          = 1'b1;
        dst_addr       = '0;
        row_len        = '0;
        rows           = '0;
        stride         = '0;
        run            = 1'b0;
        abort          = 1'b0;
        bus.src_data   = '0;
        bus.src_strobe = 1'b0;
        bus.mem_rdy    = 1'b0;
        t1_addr = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
        t2_addr = '{32'h2000, 32'h2004, 32'h2008, 32'h2100, 32'h2104, 32'h2108};
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b1);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wr", bus.mem_wr, 1'b0);
        check("rst_src_ready", bus.src_ready, 1'b0);
        check("rst_src_done", bus.src_done, 1'b1);
        check("rst_level", fifo_level, 0);

        // linear transfer, unaligned dst, back-to-back writes
        clear_log();
        start(32'h1003, 4, 1, 32'h0);
        bus.mem_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.src_strobe = 1'b1;
            bus.src_data   = 32'hA0 + 32'(i);
            tick();
        end
        bus.src_strobe = 1'b0;
        wait_idle(50);
        bus.mem_rdy = 1'b0;
        check("t1_count", log_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", log_a(i), t1_addr[i]);
            check("t1_data", (i < log_data.size()) ? log_data[i] : 32'hDEAD_BEEF, 32'hA0 + 32'(i));
            check("t1_b2b", (i < log_cyc.size()) ? log_cyc[i] - log_cyc[0] : -1, i);
        end

        // two rows with stride
        clear_log();
        start(32'h2000, 3, 2, 32'h100);
        bus.mem_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.src_strobe = 1'b1;
            bus.src_data   = $urandom;
            tick();
        end
        bus.src_strobe = 1'b0;
        check("t2_src_done", bus.src_done, 1'b1);
        wait_idle(50);
        bus.mem_rdy = 1'b0;
        check("t2_count", log_addr.size(), 6);
        for (int i = 0; i < 6; i++) check("t2_addr", log_a(i), t2_addr[i]);

        // FIFO fills while memory stalls
        clear_log();
        start(32'h3000, 8, 1, 32'h0);
        for (int i = 0; i < 5; i++) begin
            bus.src_strobe = 1'b1;
            bus.src_data   = 32'h300 + 32'(i);
            tick();
        end
        check("t3_level_full", fifo_level, 4);
        check("t3_src_ready", bus.src_ready, 1'b0);
        bus.mem_rdy = 1'b1;
        for (int i = 0; i < 200 && busy; i++) begin
            bus.src_data = 32'h400 + 32'(i);
            tick();
        end
        bus.src_strobe = 1'b0;
        wait_idle(50);
        bus.mem_rdy = 1'b0;
        check("t3_count", log_addr.size(), 8);
        check("t3_first_data", (log_data.size() > 0) ? log_data[0] : 32'hDEAD_BEEF, 32'h300);

        // abort during an in-flight write, then abort with no write pending
        start(32'h4000, 8, 1, 32'h0);
        bus.src_strobe = 1'b1;
        bus.src_data   = 32'h44;
        tick();
        bus.src_data   = 32'h45;
        tick();
        bus.src_strobe = 1'b0;
        check("t4_wr_before", bus.mem_wr, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t4_hold_wr", bus.mem_wr, 1'b1);
            check("t4_hold_addr", bus.mem_addr, 32'h4000);
            check("t4_busy", busy, 1'b1);
            tick();
        end
        bus.mem_rdy = 1'b1;
        tick();
        bus.mem_rdy = 1'b0;
        check("t4_done", done, 1'b1);
        check("t4_level", fifo_level, 0);
        check("t4_wr_after", bus.mem_wr, 1'b0);
        start(32'h4100, 4, 1, 32'h0);
        check("t4b_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4b_done", done, 1'b1);

        // zero-length runs are ignored
        start(32'h5000, 0, 5, 32'h0);
        check("t5a_busy", busy, 1'b0);
        check("t5a_src_ready", bus.src_ready, 1'b0);
        start(32'h5000, 3, 0, 32'h0);
        check("t5b_busy", busy, 1'b0);
        check("t5b_mem_wr", bus.mem_wr, 1'b0);

        // reset mid-transfer, then a fresh run
        clear_log();
        start(32'h6000, 6, 1, 32'h0);
        bus.mem_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.src_strobe = 1'b1;
            bus.src_data   = $urandom;
            tick();
        end
        bus.src_strobe = 1'b0;
        tick();
        check("t6_written", log_addr.size(), 3);
        reset = 1'b1;
        tick();
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b1);
        check("t6_mem_addr", bus.mem_addr, 32'h0);
        check("t6_mem_wr", bus.mem_wr, 1'b0);
        check("t6_src_ready", bus.src_ready, 1'b0);
        check("t6_src_done", bus.src_done, 1'b1);
        check("t6_level", fifo_level, 0);
        reset = 1'b0;
        tick();
        clear_log();
        start(32'h7008, 2, 1, 32'h0);
        for (int i = 0; i < 2; i++) begin
            bus.src_strobe = 1'b1;
            bus.src_data   = $urandom;
            tick();
        end
        bus.src_strobe = 1'b0;
        wait_idle(50);
        bus.mem_rdy = 1'b0;
        check("t6_new_addr0", log_a(0), 32'h7008);
        check("t6_new_addr1", log_a(1), 32'h700C);

        // randomized transfers against the model
        for (int k = 0; k < 24; k++) begin
            rand_xfer((k % 4) == 3);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_writer_2d.md
Name: dma_writer_2d

Overview:
Parametrised buffered DMA writer that moves a word stream from a producer into memory, one 32-bit word per bus write. It extends the single linear transfer with a 2D mode: rows of row_len words, with each row base advanced by a byte stride. It also adds configurable FIFO depth, source backpressure (src_ready), abort, back-to-back bus writes and a FIFO level output. It sits between a streaming producer (blitter, audio or video capture) and the SoC memory write port.

Parameters:
FIFO_DEPTH, 512, FIFO depth in words; must be a power of two and ≥2.
LEN_W, 16, width of the row_len and rows fields.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
dst_addr  in  32  byte address of the first word; bits [1:0] are ignored
row_len  in  LEN_W  words per row
rows  in  LEN_W  number of rows; 1 gives a plain linear transfer
stride  in  32  byte offset between row bases; bits [1:0] are ignored
run  in  1  start request, sampled only in IDLE
abort  in  1  cancel the active transfer
busy  out  1  high when not in IDLE
done  out  1  high in IDLE (level, not a pulse)
src_data  in  32  producer word
src_strobe  in  1  producer write; accepted only when src_ready is high
src_ready  out  1  the FIFO can accept a word this cycle
src_done  out  1  all words of the transfer have been accepted from the source
mem_addr  out  32  write address; bits [1:0] are always 0
mem_data  out  32  write data; asynchronous read of the FIFO head
mem_wr  out  1  write request
mem_rdy  in  1  write accepted this cycle
fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently held in the FIFO

Behaviour:
- Reset values: state IDLE, mem_addr=0, mem_wr=0, busy=0, done=1, src_ready=0, src_done=1, fifo_level=0, FIFO pointers 0. mem_data is don't-care while mem_wr=0.
- Reset mid-transfer: everything returns to the reset values on the next edge. FIFO contents are discarded and any pending write is dropped.
- States:
  - IDLE: if run=1 and row_len≠0 and rows≠0, latch the setup, set src_left = mem_left = row_len*rows (width 2*LEN_W), row_base = mem_addr = {dst_addr[31:2],2'b0}, col=0, and go to ACTIVE. A zero-length run is ignored: stay in IDLE with done=1.
  - ACTIVE, normal completion: when mem_rdy coincides with mem_left==1, go to IDLE.
  - ACTIVE, abort: if abort=1 while mem_wr=0, go to IDLE. If mem_wr=1, go to ABORT.
  - ABORT: hold mem_wr, mem_addr and mem_data until mem_rdy, then go to IDLE. Abort takes priority over completion only in the sense that the final in-flight write still finishes.
  - Entering IDLE: flush both FIFO pointers.
- run or abort while not in the state that samples them: ignored.
- Source side:
  - src_ready = (state==ACTIVE) && src_left≠0 && fifo_level<FIFO_DEPTH.
  - Push = src_strobe && src_ready. On a push: write the FIFO, increment the write pointer, decrement src_left.
  - A strobe while src_ready=0 is dropped with no side effects.
  - src_done = (src_left==0).
- FIFO:
  - Pointers are $clog2(FIFO_DEPTH)+1 bits; level = wrptr − rdptr.
  - Pointers wrap modulo 2*FIFO_DEPTH; RAM is indexed by the low bits.
  - A push and a pop in the same cycle leave the level unchanged.
- Memory side:
  - mem_wr is registered. It sets on the cycle after the FIFO becomes non-empty in ACTIVE, so first-write latency is 1 cycle after the push.
  - While mem_wr=1 and mem_rdy=0: mem_addr, mem_data and mem_wr are held stable.
  - On mem_rdy: pop (rdptr+1) and decrement mem_left.
  - mem_wr stays 1 (back-to-back) if (level − 1 + push) > 0 and mem_left > 1; otherwise it clears.
- Address generation on each accepted write:
  - If col == row_len−1: col=0, row_base = row_base + {stride[31:2],2'b0}, mem_addr = the new row_base.
  - Otherwise: col+1, mem_addr+4.
  - All address arithmetic wraps modulo 2^32. stride=0 rewrites the same row.

Test Plan:
1. dst_addr=0x1003, row_len=4, rows=1, mem_rdy tied high, 4 strobes on consecutive cycles → writes at 0x1000, 0x1004, 0x1008, 0x100C, back-to-back with data in order; done rises the cycle after the 4th mem_rdy.
2. dst_addr=0x2000, row_len=3, rows=2, stride=0x100 → write addresses 0x2000, 0x2004, 0x2008, 0x2100, 0x2104, 0x2108; src_done=1 after the 6th push.
3. FIFO_DEPTH=4, len 8, mem_rdy held low → src_ready drops after 4 pushes, the 5th strobe is dropped, fifo_level=4; releasing mem_rdy completes 8 writes with no data lost or duplicated.
4. Abort asserted while mem_wr=1 and mem_rdy is delayed 3 cycles → mem_wr and mem_addr are held, IDLE is entered after mem_rdy, fifo_level=0, done=1; abort asserted with mem_wr=0 → IDLE on the next cycle.
5. run with row_len=0 or rows=0 → busy stays 0, no mem_wr, no src_ready.
6. Reset asserted mid-transfer (3 of 6 words written) → all outputs at reset values on the next cycle; a fresh run afterwards starts at its own dst_addr.
